// File: rtl/cv32e40p_x_if_pkg.sv
// Shared types for the X-interface result return path.
// Holds the buffered result record and the starvation counter width.
package cv32e40p_x_if_pkg;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
      logic        err;
   } x_result_t;

   localparam int unsigned X_RESULT_STARVE_W = 4;

endpackage

// File: rtl/cv32e40p_x_result_fifo.sv
// Small circular buffer of accelerator results with wrap-bit pointers.
// Callers must not push when full or pop when empty; both are ignored if they do.
module cv32e40p_x_result_fifo
   import cv32e40p_x_if_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic      clk_i,
   input  logic      rst_ni,
   input  logic      push,
   input  x_result_t push_data,
   input  logic      pop,
   output logic      full,
   output logic      empty,
   output x_result_t head
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [AW:0] wptr;
   logic [AW:0] rptr;
   x_result_t   mem [DEPTH];

   logic do_push;
   logic do_pop;

   assign empty   = (wptr == rptr);
   assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rptr[AW-1:0]];

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + PTR_ONE;
         if (do_pop)  rptr <= rptr + PTR_ONE;
      end
   end

   // NOTE: storage is not reset; entries are only observable between push and pop.
   always_ff @(posedge clk_i) begin
      if (do_push) mem[wptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/cv32e40p_x_result_wb.sv
// X-interface result writeback: buffers accelerator results, arbitrates regfile port B against
// the LSU with a starvation guard. Optional 0-cycle path: define CV32E40P_X_RESULT_BYPASS_EN.
module cv32e40p_x_result_wb
   import cv32e40p_x_if_pkg::*;
#(
   parameter int unsigned DEPTH        = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        x_result_valid_i,
   output logic        x_result_ready_o,
   input  logic [4:0]  x_result_rd_i,
   input  logic [31:0] x_result_data_i,
   input  logic        x_result_we_i,
   input  logic        x_result_err_i,
   input  logic        lsu_we_wb_i,
   output logic        lsu_hold_o,
   output logic        regfile_we_o,
   output logic [4:0]  regfile_waddr_o,
   output logic [31:0] regfile_wdata_o,
   output logic        x_rvalid_o,
   output logic [4:0]  x_rwaddr_o,
   output logic        x_result_err_o,
   output logic        x_pending_o
);

   localparam logic [X_RESULT_STARVE_W-1:0] LIMIT   = X_RESULT_STARVE_W'(STARVE_LIMIT);
   localparam logic [X_RESULT_STARVE_W-1:0] CNT_ONE = X_RESULT_STARVE_W'(1);

   logic      full;
   logic      empty;
   logic      accept;
   logic      bypass;
   logic      push;
   logic      pop;
   logic      starve;
   logic      err_q;
   x_result_t head;
   x_result_t push_data;
   logic      unused_head_err;

   logic [X_RESULT_STARVE_W-1:0] starve_cnt;

   // Ready depends on registered state only, so a full FIFO never admits a result even while popping.
   assign x_result_ready_o = ~full;
   assign accept           = x_result_valid_i & x_result_ready_o;

`ifdef CV32E40P_X_RESULT_BYPASS_EN
   assign bypass = empty & accept & x_result_we_i & ~lsu_we_wb_i;
`else
   assign bypass = 1'b0;
`endif

   assign push   = accept & x_result_we_i & ~bypass;
   assign starve = (starve_cnt == LIMIT);
   assign pop    = ~empty & (~lsu_we_wb_i | starve);

   assign push_data.rd   = x_result_rd_i;
   assign push_data.data = x_result_data_i;
   assign push_data.err  = x_result_err_i;

   // The stored err bit is kept for trace visibility; the pulse is raised at accept time.
   assign unused_head_err = head.err;

   cv32e40p_x_result_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .full      (full),
      .empty     (empty),
      .head      (head)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         starve_cnt <= '0;
      end else if (pop || empty) begin
         starve_cnt <= '0;
      end else if (lsu_we_wb_i && !starve) begin
         starve_cnt <= starve_cnt + CNT_ONE;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) err_q <= 1'b0;
      else         err_q <= accept & x_result_err_i;
   end

   // NOTE: every output of this block gets a default first, so no path infers a latch.
   always_comb begin
      regfile_we_o    = 1'b0;
      regfile_waddr_o = '0;
      regfile_wdata_o = '0;
      x_rvalid_o      = 1'b0;
      x_rwaddr_o      = '0;
      if (pop) begin
         regfile_we_o    = (head.rd != 5'd0);
         regfile_waddr_o = head.rd;
         regfile_wdata_o = head.data;
         x_rvalid_o      = 1'b1;
         x_rwaddr_o      = head.rd;
      end else if (bypass) begin
         regfile_we_o    = (x_result_rd_i != 5'd0);
         regfile_waddr_o = x_result_rd_i;
         regfile_wdata_o = x_result_data_i;
         x_rvalid_o      = 1'b1;
         x_rwaddr_o      = x_result_rd_i;
      end
   end

   assign lsu_hold_o     = starve & ~empty;
   assign x_result_err_o = err_q;
   assign x_pending_o    = ~empty;

endmodule

// File: tb/tb_cv32e40p_x_result_wb.sv
// Self-checking bench for cv32e40p_x_result_wb: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the result return path.
module tb_cv32e40p_x_result_wb;
   import cv32e40p_x_if_pkg::*;

   localparam int DEPTH = 2;
   localparam int LIMIT = 4;
`ifdef CV32E40P_X_RESULT_BYPASS_EN
   localparam int LAT = 0;
`else
   localparam int LAT = 1;
`endif

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        x_result_valid_i = 1'b0;
   logic        x_result_ready_o;
   logic [4:0]  x_result_rd_i = '0;
   logic [31:0] x_result_data_i = '0;
   logic        x_result_we_i = 1'b0;
   logic        x_result_err_i = 1'b0;
   logic        lsu_we_wb_i = 1'b0;
   logic        lsu_hold_o;
   logic        regfile_we_o;
   logic [4:0]  regfile_waddr_o;
   logic [31:0] regfile_wdata_o;
   logic        x_rvalid_o;
   logic [4:0]  x_rwaddr_o;
   logic        x_result_err_o;
   logic        x_pending_o;

   int checks = 0;
   int failures = 0;

   always #5 clk_i = ~clk_i;

   cv32e40p_x_result_wb #(
      .DEPTH        (DEPTH),
      .STARVE_LIMIT (LIMIT)
   ) dut (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .x_result_valid_i (x_result_valid_i),
      .x_result_ready_o (x_result_ready_o),
      .x_result_rd_i    (x_result_rd_i),
      .x_result_data_i  (x_result_data_i),
      .x_result_we_i    (x_result_we_i),
      .x_result_err_i   (x_result_err_i),
      .lsu_we_wb_i      (lsu_we_wb_i),
      .lsu_hold_o       (lsu_hold_o),
      .regfile_we_o     (regfile_we_o),
      .regfile_waddr_o  (regfile_waddr_o),
      .regfile_wdata_o  (regfile_wdata_o),
      .x_rvalid_o       (x_rvalid_o),
      .x_rwaddr_o       (x_rwaddr_o),
      .x_result_err_o   (x_result_err_o),
      .x_pending_o      (x_pending_o)
   );

   // Reference model: queued results in acceptance order, blocked-cycle count of the head, pending err pulse.
   x_result_t mq[$];
   int        m_cnt = 0;
   bit        m_err = 1'b0;
   bit        last_acc;
   logic [47:0] exp_vec;
   logic [47:0] obs_vec;

   function automatic logic [47:0] sample_outputs();
      return {x_result_ready_o, lsu_hold_o, regfile_we_o, regfile_waddr_o, regfile_wdata_o,
              x_rvalid_o, x_rwaddr_o, x_result_err_o, x_pending_o};
   endfunction

   task automatic model_reset();
      mq.delete();
      m_cnt = 0;
      m_err = 1'b0;
   endtask

   // One clock cycle: drive inputs after the falling edge, predict and sample outputs, advance the model.
   task automatic step(input logic v, input logic [4:0] rd, input logic [31:0] d,
                       input logic we, input logic er, input logic lsu);
      bit pend, rdy, stv, acc, pop, byp;
      logic        e_we, e_rv;
      logic [4:0]  e_wa, e_ra;
      logic [31:0] e_wd;
      x_result_t   ent;
      @(negedge clk_i);
      x_result_valid_i = v;
      x_result_rd_i    = rd;
      x_result_data_i  = d;
      x_result_we_i    = we;
      x_result_err_i   = er;
      lsu_we_wb_i      = lsu;
      #1;
      pend = (mq.size() != 0);
      rdy  = (mq.size() < DEPTH);
      stv  = (m_cnt >= LIMIT);
      acc  = v && rdy;
      pop  = pend && (!lsu || stv);
      byp  = 1'b0;
`ifdef CV32E40P_X_RESULT_BYPASS_EN
      byp  = !pend && acc && we && !lsu;
`endif
      e_we = 1'b0; e_rv = 1'b0; e_wa = '0; e_ra = '0; e_wd = '0;
      if (pop) begin
         e_we = (mq[0].rd != 0); e_wa = mq[0].rd; e_wd = mq[0].data; e_rv = 1'b1; e_ra = mq[0].rd;
      end else if (byp) begin
         e_we = (rd != 0); e_wa = rd; e_wd = d; e_rv = 1'b1; e_ra = rd;
      end
      exp_vec = {rdy, stv && pend, e_we, e_wa, e_wd, e_rv, e_ra, m_err, pend};
      obs_vec = sample_outputs();
      if (pop) void'(mq.pop_front());
      if (acc && we && !byp) begin
         ent.rd = rd; ent.data = d; ent.err = er;
         mq.push_back(ent);
      end
      if (pop || !pend) m_cnt = 0;
      else if (lsu && m_cnt < LIMIT) m_cnt++;
      m_err    = acc && er;
      last_acc = acc;
   endtask

   task automatic drain();
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (sample_outputs() !== 48'h8000_0000_0000) begin
         failures++;
         $display("FAIL reset_values got=%h exp=%h", sample_outputs(), 48'h8000_0000_0000);
      end
      @(negedge clk_i);
      rst_ni = 1'b1;
      model_reset();
   endtask

   task automatic test_single();
      drain();
      for (int i = 0; i < 3; i++) begin
         if (i == 0) step(1, 5, 32'hDEAD_BEEF, 1, 0, 0);
         else        step(0, 0, 0, 0, 0, 0);
         checks++;
         if (obs_vec !== exp_vec) begin
            failures++;
            $display("FAIL single cyc%0d got=%h exp=%h", i, obs_vec, exp_vec);
         end
         if (i == LAT) begin
            checks++;
            if ({regfile_we_o, regfile_waddr_o, regfile_wdata_o, x_rvalid_o} !== {1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1}) begin
               failures++;
               $display("FAIL single_write we=%b waddr=%0d wdata=%h rvalid=%b exp 1/5/deadbeef/1",
                        regfile_we_o, regfile_waddr_o, regfile_wdata_o, x_rvalid_o);
            end
         end
      end
   endtask

   task automatic test_fill();
      logic [31:0] got[$];
      logic [31:0] want[3];
      int          cyc;
      want[0] = 32'h1111_0001; want[1] = 32'h2222_0002; want[2] = 32'h3333_0003;
      drain();
      for (int i = 0; i < 3; i++) begin
         step(1, 5'(i + 1), want[i], 1, 0, 1);
         if (x_rvalid_o) got.push_back(regfile_wdata_o);
         checks++;
         if (obs_vec !== exp_vec) begin
            failures++;
            $display("FAIL fill_push%0d got=%h exp=%h", i, obs_vec, exp_vec);
         end
      end
      checks++;
      if (x_result_ready_o !== 1'b0 || last_acc) begin
         failures++;
         $display("FAIL fill_ready ready=%b exp 0 after two accepts", x_result_ready_o);
      end
      cyc = 0;
      last_acc = 1'b0;
      while (!last_acc && cyc < 10) begin
         step(1, 5'd3, want[2], 1, 0, 0);
         if (x_rvalid_o) got.push_back(regfile_wdata_o);
         checks++;
         if (obs_vec !== exp_vec) begin
            failures++;
            $display("FAIL fill_hold cyc%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
         end
         cyc++;
      end
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0, 0, 0, 0);
         if (x_rvalid_o) got.push_back(regfile_wdata_o);
      end
      checks++;
      if (got.size() != 3 || got[0] !== want[0] || got[1] !== want[1] || got[2] !== want[2]) begin
         failures++;
         $display("FAIL fill_order writes=%0d exp 3 in acceptance order", got.size());
      end
   endtask

   task automatic test_starve();
      drain();
      step(1, 7, 32'hCAFE_0007, 1, 0, 1);
      for (int i = 1; i <= 6; i++) begin
         step(0, 0, 0, 0, 0, 1);
         checks++;
         if (obs_vec !== exp_vec || lsu_hold_o !== (i == 5) || x_rvalid_o !== (i == 5)) begin
            failures++;
            $display("FAIL starve cyc%0d hold=%b rvalid=%b got=%h exp=%h", i, lsu_hold_o, x_rvalid_o, obs_vec, exp_vec);
         end
      end
   endtask

   task automatic test_rd0();
      drain();
      for (int i = 0; i < 2; i++) begin
         if (i == 0) step(1, 0, 32'h0BAD_F00D, 1, 0, 0);
         else        step(0, 0, 0, 0, 0, 0);
         checks++;
         if (obs_vec !== exp_vec) begin
            failures++;
            $display("FAIL rd0 cyc%0d got=%h exp=%h", i, obs_vec, exp_vec);
         end
         if (i == LAT) begin
            checks++;
            if ({x_rvalid_o, x_rwaddr_o, regfile_we_o} !== {1'b1, 5'd0, 1'b0}) begin
               failures++;
               $display("FAIL rd0_strobe rvalid=%b rwaddr=%0d we=%b exp 1/0/0", x_rvalid_o, x_rwaddr_o, regfile_we_o);
            end
         end
      end
   endtask

   task automatic test_err_nowe();
      drain();
      for (int i = 0; i < 3; i++) begin
         if (i == 0) step(1, 9, 32'h1234_5678, 0, 1, 0);
         else        step(0, 0, 0, 0, 0, 0);
         checks++;
         if (obs_vec !== exp_vec || x_result_err_o !== (i == 1) || x_rvalid_o !== 1'b0 || x_pending_o !== 1'b0) begin
            failures++;
            $display("FAIL err_nowe cyc%0d err=%b rvalid=%b pending=%b got=%h exp=%h",
                     i, x_result_err_o, x_rvalid_o, x_pending_o, obs_vec, exp_vec);
         end
      end
   endtask

   task automatic test_random();
      int errs = 0;
      drain();
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom,
              1'($urandom_range(0, 99) < 80), 1'($urandom_range(0, 99) < 15),
              1'($urandom_range(0, 99) < 70));
         checks++;
         if (obs_vec !== exp_vec) begin
            failures++;
            if (errs++ < 10) $display("FAIL random cyc%0d got=%h exp=%h", i, obs_vec, exp_vec);
         end
      end
   endtask

   task automatic test_reset_mid();
      drain();
      step(1, 3, 32'hAAAA_0003, 1, 0, 1);
      step(1, 4, 32'hBBBB_0004, 1, 0, 1);
      @(negedge clk_i);
      x_result_valid_i = 1'b0;
      rst_ni = 1'b0;
      #1;
      checks++;
      if (x_pending_o !== 1'b0 || x_result_ready_o !== 1'b1) begin
         failures++;
         $display("FAIL reset_mid pending=%b ready=%b exp 0/1", x_pending_o, x_result_ready_o);
      end
      model_reset();
      @(negedge clk_i);
      rst_ni = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0, 0, 0, 0);
         checks++;
         if (obs_vec !== exp_vec || regfile_we_o !== 1'b0 || x_rvalid_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_idle cyc%0d got=%h exp=%h", i, obs_vec, exp_vec);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill();
      test_starve();
      test_rd0();
      test_err_nowe();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
